// File: rtl/branch_ctrl.sv
// ID-stage branch resolution sequencer: holds the front end until comparator
// operands are forwarded, issues taken/link pulses, and keeps branch statistics.
module branch_ctrl #(
  parameter int CNT_W    = 32,
  parameter int MAX_WAIT = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             id_valid,
  input  logic             id_branch,
  input  logic             id_need_rt,
  input  logic             id_link,
  input  logic             rs_ready,
  input  logic             rt_ready,
  input  logic             cmpout,
  output logic             stall,
  output logic             taken,
  output logic             link_we,
  output logic             err,
  output logic [CNT_W-1:0] branch_cnt,
  output logic [CNT_W-1:0] taken_cnt,
  output logic [CNT_W-1:0] stall_cnt
);

  // state | meaning
  // IDLE  | no branch held in ID; a ready request resolves immediately
  // WAIT  | branch stalled for operands; wcnt counts stall cycles so far
  localparam int WW = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
  localparam logic [WW-1:0] WAIT_LIMIT = WW'(MAX_WAIT);

  typedef enum logic {IDLE = 1'b0, WAIT = 1'b1} state_t;

  state_t        state;
  logic [WW-1:0] wcnt;
  logic          req;
  logic          ready;
  logic          resolve;
  logic          timeout;

  assign req   = id_valid & id_branch;
  assign ready = rs_ready & (rt_ready | ~id_need_rt);

  // Mealy outputs; reset gates them so nothing leaks while held in reset.
  always_comb begin
    stall   = 1'b0;
    taken   = 1'b0;
    link_we = 1'b0;
    resolve = 1'b0;
    timeout = 1'b0;
    if (!reset && req) begin
      if (ready) begin
        resolve = 1'b1;
        taken   = cmpout;
        link_we = id_link;
      end else if (state == IDLE || wcnt != WAIT_LIMIT) begin
        stall = 1'b1;
      end else begin
        // Operands never arrived: release ID as not-taken and flag it.
        resolve = 1'b1;
        timeout = 1'b1;
        link_we = id_link;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      wcnt       <= '0;
      err        <= 1'b0;
      branch_cnt <= '0;
      taken_cnt  <= '0;
      stall_cnt  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (stall) begin
            state <= WAIT;
            wcnt  <= WW'(1);
          end
        end
        WAIT: begin
          if (!req || resolve) begin
            state <= IDLE;
            wcnt  <= '0;
          end else begin
            wcnt <= wcnt + WW'(1);
          end
        end
        default: begin
          state <= IDLE;
          wcnt  <= '0;
        end
      endcase

      if (timeout) err <= 1'b1;
      if (resolve) branch_cnt <= branch_cnt + CNT_W'(1);
      if (taken)   taken_cnt  <= taken_cnt + CNT_W'(1);
      if (stall)   stall_cnt  <= stall_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_branch_ctrl.sv
// Bench for branch_ctrl: directed scenarios then random traffic, both checked
// against a stall-budget model; a narrow-counter instance exercises wrap.
module tb_branch_ctrl;
  localparam int MAX_WAIT = 3;

  logic clk;
  logic reset;
  logic id_valid, id_branch, id_need_rt, id_link, rs_ready, rt_ready, cmpout;
  logic stall, taken, link_we, err;
  logic [31:0] branch_cnt, taken_cnt, stall_cnt;
  logic stall_w, taken_w, link_we_w, err_w;
  logic [1:0] branch_cnt_w, taken_cnt_w, stall_cnt_w;

  int checks = 0;
  int errors = 0;

  // reference model state
  int m_waited;
  int m_bcnt, m_tcnt, m_scnt;
  bit m_err;

  branch_ctrl #(.CNT_W(32), .MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_branch(id_branch),
    .id_need_rt(id_need_rt), .id_link(id_link), .rs_ready(rs_ready),
    .rt_ready(rt_ready), .cmpout(cmpout), .stall(stall), .taken(taken),
    .link_we(link_we), .err(err), .branch_cnt(branch_cnt),
    .taken_cnt(taken_cnt), .stall_cnt(stall_cnt)
  );

  branch_ctrl #(.CNT_W(2), .MAX_WAIT(MAX_WAIT)) dut_w (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_branch(id_branch),
    .id_need_rt(id_need_rt), .id_link(id_link), .rs_ready(rs_ready),
    .rt_ready(rt_ready), .cmpout(cmpout), .stall(stall_w), .taken(taken_w),
    .link_we(link_we_w), .err(err_w), .branch_cnt(branch_cnt_w),
    .taken_cnt(taken_cnt_w), .stall_cnt(stall_cnt_w)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One cycle: drive at negedge, check just after, then advance the model.
  task automatic tick(input bit rst, input bit v, input bit b, input bit nrt,
                      input bit lnk, input bit rs, input bit rt, input bit cmp);
    bit req, rdy, e_st, e_tk, e_lk;
    @(negedge clk);
    reset = rst; id_valid = v; id_branch = b; id_need_rt = nrt;
    id_link = lnk; rs_ready = rs; rt_ready = rt; cmpout = cmp;
    #1;
    if (rst) begin
      m_waited = 0; m_bcnt = 0; m_tcnt = 0; m_scnt = 0; m_err = 0;
    end
    chk("branch_cnt", branch_cnt, m_bcnt);
    chk("taken_cnt", taken_cnt, m_tcnt);
    chk("stall_cnt", stall_cnt, m_scnt);
    chk("err", {31'b0, err}, {31'b0, m_err});
    chk("branch_cnt_w", {30'b0, branch_cnt_w}, m_bcnt & 3);
    chk("taken_cnt_w", {30'b0, taken_cnt_w}, m_tcnt & 3);
    chk("stall_cnt_w", {30'b0, stall_cnt_w}, m_scnt & 3);

    req = v & b;
    rdy = rs & (rt | ~nrt);
    e_st = 0; e_tk = 0; e_lk = 0;
    if (rst || !req) begin
      m_waited = 0;
    end else if (rdy) begin
      e_tk = cmp; e_lk = lnk;
      m_bcnt++; if (cmp) m_tcnt++;
      m_waited = 0;
    end else if (m_waited < MAX_WAIT) begin
      e_st = 1;
      m_scnt++;
      m_waited++;
    end else begin
      e_lk = lnk;
      m_bcnt++; m_err = 1;
      m_waited = 0;
    end
    chk("stall", {31'b0, stall}, {31'b0, e_st});
    chk("taken", {31'b0, taken}, {31'b0, e_tk});
    chk("link_we", {31'b0, link_we}, {31'b0, e_lk});
    chk("stall_w", {31'b0, stall_w}, {31'b0, e_st});
  endtask

  task automatic idle();
    tick(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    tick(1, 1, 1, 1, 1, 0, 0, 1);
  endtask

  initial begin
    reset = 1'b1; id_valid = 0; id_branch = 0; id_need_rt = 0; id_link = 0;
    rs_ready = 0; rt_ready = 0; cmpout = 0;
    m_waited = 0; m_bcnt = 0; m_tcnt = 0; m_scnt = 0; m_err = 0;

    // reset holds outputs low even with a pending unready request
    do_reset();
    chk("rst_stall", {31'b0, stall}, 32'd0);

    // ready beq, taken
    do_reset();
    tick(0, 1, 1, 1, 0, 1, 1, 1);
    chk("s1_taken", {31'b0, taken}, 32'd1);
    idle();
    chk("s1_bcnt", branch_cnt, 32'd1);
    chk("s1_tcnt", taken_cnt, 32'd1);
    chk("s1_scnt", stall_cnt, 32'd0);

    // load-use: two stalls then resolve not-taken
    do_reset();
    tick(0, 1, 1, 1, 0, 0, 1, 0);
    tick(0, 1, 1, 1, 0, 0, 1, 0);
    tick(0, 1, 1, 1, 0, 1, 1, 0);
    idle();
    chk("s2_scnt", stall_cnt, 32'd2);
    chk("s2_bcnt", branch_cnt, 32'd1);
    chk("s2_tcnt", taken_cnt, 32'd0);
    chk("s2_err", {31'b0, err}, 32'd0);

    // bgez: rt not needed
    do_reset();
    tick(0, 1, 1, 0, 0, 1, 0, 1);
    chk("s3_taken", {31'b0, taken}, 32'd1);
    chk("s3_stall", {31'b0, stall}, 32'd0);

    // timeout: three stalls then forced not-taken, err sticky
    do_reset();
    for (int i = 0; i < 3; i++) tick(0, 1, 1, 1, 0, 0, 1, 1);
    tick(0, 1, 1, 1, 0, 0, 1, 1);
    chk("s4_forced_stall", {31'b0, stall}, 32'd0);
    chk("s4_forced_taken", {31'b0, taken}, 32'd0);
    idle();
    chk("s4_err", {31'b0, err}, 32'd1);
    chk("s4_scnt", stall_cnt, 32'd3);
    tick(0, 1, 1, 1, 0, 1, 1, 1);
    idle();
    chk("s4_err_sticky", {31'b0, err}, 32'd1);

    // bgezal not taken still links
    do_reset();
    tick(0, 1, 1, 0, 1, 1, 0, 0);
    chk("s5_link", {31'b0, link_we}, 32'd1);
    chk("s5_taken", {31'b0, taken}, 32'd0);

    // back-to-back branches, second one stalls from IDLE
    tick(0, 1, 1, 1, 0, 1, 1, 1);
    tick(0, 1, 1, 1, 0, 0, 0, 1);
    chk("s6_b2b_stall", {31'b0, stall}, 32'd1);

    // reset mid-WAIT after one stall cycle
    do_reset();
    tick(0, 1, 1, 1, 0, 0, 1, 0);
    do_reset();
    chk("s7_stall", {31'b0, stall}, 32'd0);
    chk("s7_scnt", stall_cnt, 32'd0);
    tick(0, 1, 1, 1, 0, 0, 1, 0);
    tick(0, 1, 1, 1, 0, 0, 1, 0);
    tick(0, 1, 1, 1, 0, 0, 1, 0);
    chk("s7_fresh_stall", {31'b0, stall}, 32'd1);
    idle();

    // counter wrap on the 2-bit instance: five taken -> 1
    do_reset();
    for (int i = 0; i < 5; i++) tick(0, 1, 1, 1, 0, 1, 1, 1);
    idle();
    chk("s8_wrap_tcnt", {30'b0, taken_cnt_w}, 32'd1);
    chk("s8_full_tcnt", taken_cnt, 32'd5);

    // random traffic
    for (int i = 0; i < 600; i++) begin
      tick(($urandom % 97) == 0, ($urandom % 8) != 0, ($urandom % 4) != 0,
           $urandom % 2, $urandom % 2, ($urandom % 3) != 0, $urandom % 2,
           $urandom % 2);
    end
    idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
